tap_controller: RTL and testbench
=================================

# tap_controller

IEEE 1149.1-style TAP controller for the JTAG block. It runs the 16-state TAP state machine from TMS and holds the 2-bit instruction register whose decoded value drives CODE into the TDO select mux. It generates capture/shift/update strobes for the BSR, BYPASS and DEVICE_ID data registers and drives the final TDO from the IR or the data-register mux output.

## Interface
Parameters:
- IR_RESET, 2'h2, instruction loaded on reset/Test-Logic-Reset (DEVICE_ID).
- IR_CAPTURE, 2'b01, value parallel-loaded into the IR shift stage in Capture-IR.

Ports:
- TCK  in  1  test clock; the only clock.
- TRST  in  1  reset, asynchronous, active-high.
- TMS  in  1  mode select, sampled on rising TCK.
- TDI  in  1  serial data in, sampled on rising TCK.
- G1_TDO  in  1  serial output of the data-register mux.
- CODE  out  2  active instruction: 0 BYPASS, 1 BSR, 2 DEVICE_ID.
- CAPTURE_DR  out  1  high while the state is Capture-DR.
- SHIFT_DR  out  1  high while the state is Shift-DR.
- UPDATE_DR  out  1  high while the state is Update-DR.
- TEST_LOGIC_RESET  out  1  high while the state is Test-Logic-Reset.
- TDO  out  1  serial data out, registered on falling TCK.
- TDO_EN  out  1  TDO valid/drive enable, registered on falling TCK.

## Operation
- States follow IEEE 1149.1:
  - Test-Logic-Reset (TLR): TMS 0 → Run-Test/Idle (RTI), TMS 1 → TLR.
  - RTI: 0 → RTI, 1 → Select-DR.
  - Select-DR: 0 → Capture-DR, 1 → Select-IR.
  - Select-IR: 0 → Capture-IR, 1 → TLR.
  - Capture-x: 0 → Shift-x, 1 → Exit1-x.
  - Shift-x: 0 → Shift-x, 1 → Exit1-x.
  - Exit1-x: 0 → Pause-x, 1 → Update-x.
  - Pause-x: 0 → Pause-x, 1 → Exit2-x.
  - Exit2-x: 0 → Shift-x, 1 → Update-x.
  - Update-x: 0 → RTI, 1 → Select-DR.
- Five consecutive TMS=1 rising edges reach TLR from any state.
- IR shift stage (2 bits), on rising TCK:
  - In Capture-IR it loads IR_CAPTURE.
  - In Shift-IR it shifts right with TDI entering the MSB.
  - It holds in every other state.
- IR latch, on rising TCK:
  - In Update-IR it loads the shift stage; value 2'h3 is stored as 2'h0 (BYPASS).
  - In TLR it loads IR_RESET.
- CODE is the IR latch output directly.
- DR strobes and TEST_LOGIC_RESET are Moore decodes of the current state. A data register acts on the rising edge that ends the strobed state.
- TDO source:
  - Shift-IR: IR shift stage bit 0, TDO_EN=1.
  - Shift-DR: G1_TDO, TDO_EN=1.
  - Otherwise: TDO=0, TDO_EN=0.
- Reset values: state TLR, IR shift stage 2'b00, IR latch and CODE = IR_RESET, TDO=0, TDO_EN=0, TEST_LOGIC_RESET=1, CAPTURE_DR=SHIFT_DR=UPDATE_DR=0.

## Timing
- State, IR shift stage and IR latch update on rising TCK.
- TDO and TDO_EN update on falling TCK, half a cycle after the state change.
- CODE changes on the rising edge that leaves Update-IR. The new CODE is visible in the following RTI or Select-DR.
- TRST asserts all registers immediately, both rising- and falling-edge domains, and overrides any state including mid-shift. The IR latch returns to IR_RESET.
- Pause-IR/Pause-DR and Exit2 → Shift preserve the IR shift stage contents with no bit lost or duplicated.
- Select-IR with TMS=1 goes to TLR and resets CODE on that edge.
- TDO/TDO_EN stay 0 in Capture, Exit, Pause and Update states.

## Structure
- Shared package jtag_pkg holds:
  - a 4-bit state enum with IEEE names;
  - the instruction constants BYPASS=2'h0, BSR=2'h1, DEVICE_ID=2'h2.
- Sub-module tap_fsm contains the state register, next-state logic and state decodes.
- tap_controller instantiates tap_fsm and adds the IR shift stage, the IR latch and the falling-edge TDO stage.

## Test plan
- Reset mid-operation: assert TRST while in Shift-DR with CODE=1 → state TLR, CODE=2, TDO_EN=0, TEST_LOGIC_RESET=1 without waiting for a TCK edge.
- TMS=1 for 5 TCKs starting in Shift-IR → TLR after the 5th edge, CODE=2. Also cover starting in Pause-DR with the same result.
- Load BSR: TMS 0,1,1,0,0 → Shift-IR; shift TDI 1 (TMS 0), then TDI 0 (TMS 1); then TMS 1, 0 → Update-IR, RTI.
  - TDO emits 1 then 0, the captured 01 LSB first.
  - CODE=1 in RTI.
- Load code 3 by the same sequence with TDI 1,1 → CODE=0 (BYPASS).
- DR scan: TMS 1,0,0 from RTI → Capture-DR; then 4 Shift-DR cycles with G1_TDO=1,0,1,1; then Exit1, Update.
  - CAPTURE_DR high exactly 1 cycle.
  - SHIFT_DR high 4 cycles.
  - TDO 1,0,1,1 half-cycle delayed.
  - UPDATE_DR high 1 cycle.
- Pause: shift 1 bit of IR, go Exit1 → Pause (3 cycles) → Exit2 → Shift, shift the 2nd bit, update → CODE equals the two TDI bits and TDO_EN=0 throughout Pause.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state names and instruction codes.
package jtag_pkg;

   // IEEE 1149.1 TAP controller states
   typedef enum logic [3:0] {
      ST_TEST_LOGIC_RESET = 4'h0,
      ST_RUN_TEST_IDLE    = 4'h1,
      ST_SELECT_DR_SCAN   = 4'h2,
      ST_CAPTURE_DR       = 4'h3,
      ST_SHIFT_DR         = 4'h4,
      ST_EXIT1_DR         = 4'h5,
      ST_PAUSE_DR         = 4'h6,
      ST_EXIT2_DR         = 4'h7,
      ST_UPDATE_DR        = 4'h8,
      ST_SELECT_IR_SCAN   = 4'h9,
      ST_CAPTURE_IR       = 4'hA,
      ST_SHIFT_IR         = 4'hB,
      ST_EXIT1_IR         = 4'hC,
      ST_PAUSE_IR         = 4'hD,
      ST_EXIT2_IR         = 4'hE,
      ST_UPDATE_IR        = 4'hF
   } tap_state_e;

   localparam logic [1:0] BYPASS    = 2'h0;
   localparam logic [1:0] BSR       = 2'h1;
   localparam logic [1:0] DEVICE_ID = 2'h2;

   // Unused instruction encoding 2'h3 falls back to BYPASS
   function automatic logic [1:0] ir_decode(input logic [1:0] ir);
      return (ir == 2'h3) ? BYPASS : ir;
   endfunction

endpackage

// File: rtl/tap_fsm.sv
// TAP state machine: state register, TMS-driven next state and state decodes.
module tap_fsm
   import jtag_pkg::*;
(
   input  logic tck_i,
   input  logic trst_i,
   input  logic tms_i,
   output logic enter_tlr_o,
   output logic tlr_o,
   output logic capture_dr_o,
   output logic shift_dr_o,
   output logic update_dr_o,
   output logic capture_ir_o,
   output logic shift_ir_o,
   output logic update_ir_o
);

   tap_state_e state_q, state_d;

   // State register, forced to Test-Logic-Reset by TRST
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) state_q <= ST_TEST_LOGIC_RESET;
      else        state_q <= state_d;
   end

   // Next-state from TMS plus Moore decodes of the current state
   always_comb begin
      state_d      = state_q;
      tlr_o        = 1'b0;
      capture_dr_o = 1'b0;
      shift_dr_o   = 1'b0;
      update_dr_o  = 1'b0;
      capture_ir_o = 1'b0;
      shift_ir_o   = 1'b0;
      update_ir_o  = 1'b0;

      unique case (state_q)
         ST_TEST_LOGIC_RESET: state_d = tms_i ? ST_TEST_LOGIC_RESET : ST_RUN_TEST_IDLE;
         ST_RUN_TEST_IDLE:    state_d = tms_i ? ST_SELECT_DR_SCAN   : ST_RUN_TEST_IDLE;
         ST_SELECT_DR_SCAN:   state_d = tms_i ? ST_SELECT_IR_SCAN   : ST_CAPTURE_DR;
         ST_CAPTURE_DR:       state_d = tms_i ? ST_EXIT1_DR         : ST_SHIFT_DR;
         ST_SHIFT_DR:         state_d = tms_i ? ST_EXIT1_DR         : ST_SHIFT_DR;
         ST_EXIT1_DR:         state_d = tms_i ? ST_UPDATE_DR        : ST_PAUSE_DR;
         ST_PAUSE_DR:         state_d = tms_i ? ST_EXIT2_DR         : ST_PAUSE_DR;
         ST_EXIT2_DR:         state_d = tms_i ? ST_UPDATE_DR        : ST_SHIFT_DR;
         ST_UPDATE_DR:        state_d = tms_i ? ST_SELECT_DR_SCAN   : ST_RUN_TEST_IDLE;
         ST_SELECT_IR_SCAN:   state_d = tms_i ? ST_TEST_LOGIC_RESET : ST_CAPTURE_IR;
         ST_CAPTURE_IR:       state_d = tms_i ? ST_EXIT1_IR         : ST_SHIFT_IR;
         ST_SHIFT_IR:         state_d = tms_i ? ST_EXIT1_IR         : ST_SHIFT_IR;
         ST_EXIT1_IR:         state_d = tms_i ? ST_UPDATE_IR        : ST_PAUSE_IR;
         ST_PAUSE_IR:         state_d = tms_i ? ST_EXIT2_IR         : ST_PAUSE_IR;
         ST_EXIT2_IR:         state_d = tms_i ? ST_UPDATE_IR        : ST_SHIFT_IR;
         ST_UPDATE_IR:        state_d = tms_i ? ST_SELECT_DR_SCAN   : ST_RUN_TEST_IDLE;
         default:             state_d = ST_TEST_LOGIC_RESET;
      endcase

      tlr_o        = (state_q == ST_TEST_LOGIC_RESET);
      capture_dr_o = (state_q == ST_CAPTURE_DR);
      shift_dr_o   = (state_q == ST_SHIFT_DR);
      update_dr_o  = (state_q == ST_UPDATE_DR);
      capture_ir_o = (state_q == ST_CAPTURE_IR);
      shift_ir_o   = (state_q == ST_SHIFT_IR);
      update_ir_o  = (state_q == ST_UPDATE_IR);
   end

   // Entering (or staying in) TLR lets the IR latch reset on that same edge
   assign enter_tlr_o = (state_d == ST_TEST_LOGIC_RESET);

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP controller: TAP FSM, 2-bit instruction register and falling-edge TDO stage.
module tap_controller
   import jtag_pkg::*;
#(
   parameter logic [1:0] IR_RESET   = 2'h2,
   parameter logic [1:0] IR_CAPTURE = 2'b01
) (
   input  logic       TCK,
   input  logic       TRST,
   input  logic       TMS,
   input  logic       TDI,
   input  logic       G1_TDO,
   output logic [1:0] CODE,
   output logic       CAPTURE_DR,
   output logic       SHIFT_DR,
   output logic       UPDATE_DR,
   output logic       TEST_LOGIC_RESET,
   output logic       TDO,
   output logic       TDO_EN
);

   logic       enter_tlr, capture_ir, shift_ir, update_ir;
   logic [1:0] ir_shift_q, ir_shift_d;
   logic [1:0] ir_latch_q, ir_latch_d;
   logic       tdo_q, tdo_d;
   logic       tdo_en_q, tdo_en_d;

   tap_fsm u_fsm (
      .tck_i        (TCK),
      .trst_i       (TRST),
      .tms_i        (TMS),
      .enter_tlr_o  (enter_tlr),
      .tlr_o        (TEST_LOGIC_RESET),
      .capture_dr_o (CAPTURE_DR),
      .shift_dr_o   (SHIFT_DR),
      .update_dr_o  (UPDATE_DR),
      .capture_ir_o (capture_ir),
      .shift_ir_o   (shift_ir),
      .update_ir_o  (update_ir)
   );

   // IR shift stage next value: capture, shift right with TDI into MSB, else hold
   always_comb begin
      ir_shift_d = ir_shift_q;
      if (capture_ir)    ir_shift_d = IR_CAPTURE;
      else if (shift_ir) ir_shift_d = {TDI, ir_shift_q[1]};
   end

   // IR shift stage register
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) ir_shift_q <= '0;
      else      ir_shift_q <= ir_shift_d;
   end

   // IR latch next value: reset instruction on TLR entry, decoded shift stage on Update-IR
   always_comb begin
      ir_latch_d = ir_latch_q;
      if (enter_tlr)      ir_latch_d = IR_RESET;
      else if (update_ir) ir_latch_d = ir_decode(ir_shift_q);
   end

   // IR latch register
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) ir_latch_q <= IR_RESET;
      else      ir_latch_q <= ir_latch_d;
   end

   assign CODE = ir_latch_q;

   // TDO source select: IR LSB in Shift-IR, data-register mux in Shift-DR
   always_comb begin
      tdo_d    = 1'b0;
      tdo_en_d = 1'b0;
      if (shift_ir) begin
         tdo_d    = ir_shift_q[0];
         tdo_en_d = 1'b1;
      end else if (SHIFT_DR) begin
         tdo_d    = G1_TDO;
         tdo_en_d = 1'b1;
      end
   end

   // TDO output stage, retimed to the falling edge of TCK
   always_ff @(negedge TCK or posedge TRST) begin
      if (TRST) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         tdo_q    <= tdo_d;
         tdo_en_q <= tdo_en_d;
      end
   end

   assign TDO    = tdo_q;
   assign TDO_EN = tdo_en_q;

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: table-driven TAP reference model, directed scans plus random TMS.
module tb_tap_controller;

   logic       TCK = 1'b0;
   logic       TRST = 1'b1;
   logic       TMS = 1'b1;
   logic       TDI = 1'b0;
   logic       G1_TDO = 1'b0;
   logic [1:0] CODE;
   logic       CAPTURE_DR, SHIFT_DR, UPDATE_DR, TEST_LOGIC_RESET, TDO, TDO_EN;

   tap_controller #(.IR_RESET(2'h2), .IR_CAPTURE(2'b01)) dut (
      .TCK              (TCK),
      .TRST             (TRST),
      .TMS              (TMS),
      .TDI              (TDI),
      .G1_TDO           (G1_TDO),
      .CODE             (CODE),
      .CAPTURE_DR       (CAPTURE_DR),
      .SHIFT_DR         (SHIFT_DR),
      .UPDATE_DR        (UPDATE_DR),
      .TEST_LOGIC_RESET (TEST_LOGIC_RESET),
      .TDO              (TDO),
      .TDO_EN           (TDO_EN)
   );

   always #5 TCK = ~TCK;

   // Reference model state numbering (independent of the RTL encoding)
   localparam int M_TLR = 0,  M_RTI = 1,  M_SDR = 2,  M_CDR = 3;
   localparam int M_SHDR = 4, M_E1DR = 5, M_PDR = 6,  M_E2DR = 7;
   localparam int M_UDR = 8,  M_SIR = 9,  M_CIR = 10, M_SHIR = 11;
   localparam int M_E1IR = 12, M_PIR = 13, M_E2IR = 14, M_UIR = 15;

   int nxt0[16] = '{M_RTI, M_RTI, M_CDR, M_SHDR, M_SHDR, M_PDR, M_PDR, M_SHDR,
                    M_RTI, M_CIR, M_SHIR, M_SHIR, M_PIR, M_PIR, M_SHIR, M_RTI};
   int nxt1[16] = '{M_TLR, M_SDR, M_SIR, M_E1DR, M_E1DR, M_UDR, M_E2DR, M_UDR,
                    M_SDR, M_TLR, M_E1IR, M_E1IR, M_UIR, M_E2IR, M_UIR, M_SDR};

   int m_st;
   int m_shift;
   int m_code;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_cap = 0, n_shdr = 0, n_upd = 0;

   logic [6:0] exp_q[$];

   task automatic model_reset();
      m_st = M_TLR;
      m_shift = 0;
      m_code = 2;
   endtask

   task automatic model_edge(input logic tms, input logic tdi);
      int nx;
      nx = tms ? nxt1[m_st] : nxt0[m_st];
      if (nx == M_TLR)       m_code = 2;
      else if (m_st == M_UIR) m_code = (m_shift == 3) ? 0 : m_shift;
      if (m_st == M_CIR)       m_shift = 1;
      else if (m_st == M_SHIR) m_shift = (m_shift / 2) + (int'(tdi) * 2);
      m_st = nx;
   endtask

   // Expected {CODE, CAPTURE_DR, SHIFT_DR, UPDATE_DR, TLR, TDO, TDO_EN} for the current cycle
   function automatic logic [6:0] exp_vec(input logic g1);
      logic [1:0] c;
      logic tdo, en;
      c = 2'(m_code);
      tdo = 1'b0;
      en = 1'b0;
      if (m_st == M_SHIR) begin tdo = 1'((m_shift % 2)); en = 1'b1; end
      if (m_st == M_SHDR) begin tdo = g1; en = 1'b1; end
      return {c, m_st == M_CDR, m_st == M_SHDR, m_st == M_UDR, m_st == M_TLR, tdo, en};
   endfunction

   function automatic logic [6:0] act_vec();
      return {CODE, CAPTURE_DR, SHIFT_DR, UPDATE_DR, TEST_LOGIC_RESET, TDO, TDO_EN};
   endfunction

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Monitor: one output sample per cycle, half a cycle after the state change
   initial begin
      logic [6:0] e;
      logic [6:0] a;
      forever begin
         @(negedge TCK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_vec();
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL scoreboard cycle %0d {code,cap,shdr,upd,tlr,tdo,en}: got %b expected %b",
                        cyc, a, e);
            end
            if (CAPTURE_DR) n_cap++;
            if (SHIFT_DR)   n_shdr++;
            if (UPDATE_DR)  n_upd++;
            cyc++;
         end
      end
   end

   task automatic step(input logic tms, input logic tdi, input logic g1);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      model_edge(tms, tdi);
      #1;
      G1_TDO = g1;
      exp_q.push_back(exp_vec(g1));
   endtask

   task automatic async_reset(input string name);
      @(negedge TCK);
      #2;
      TRST = 1'b1;
      #1;
      model_reset();
      chk(name, act_vec(), {2'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      #1;
      TRST = 1'b0;
   endtask

   // From RTI/TLR-with-TMS0 path: reach Shift-IR, shift two bits, update, back to RTI
   task automatic load_ir(input logic b0, input logic b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, b0, 1'b0);
      step(1'b1, b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int c0, s0, u0;
      model_reset();
      #2;
      chk("power_on_reset", act_vec(), {2'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      #1;
      TRST = 1'b0;

      // Load BSR: TLR -> RTI, then IR scan shifting 1,0
      step(1'b0, 1'b0, 1'b0);
      load_ir(1'b1, 1'b0);
      chk("code_bsr_in_rti", {5'b0, CODE}, {5'b0, 2'h1});

      // DR scan with G1_TDO 1,0,1,1
      c0 = n_cap; s0 = n_shdr; u0 = n_upd;
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      @(negedge TCK); #2;
      chk("capture_dr_cycles", 7'(n_cap - c0), 7'd1);
      chk("shift_dr_cycles",   7'(n_shdr - s0), 7'd4);
      chk("update_dr_cycles",  7'(n_upd - u0), 7'd1);

      // Reset mid Shift-DR with CODE=1
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      async_reset("reset_mid_shift_dr");

      // Five TMS=1 from Shift-IR
      step(1'b0, 1'b0, 1'b0);
      load_ir(1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
      chk("tms5_from_shift_ir", {4'b0, CODE, TEST_LOGIC_RESET}, {4'b0, 2'h2, 1'b1});

      // Five TMS=1 from Pause-DR
      step(1'b0, 1'b0, 1'b0);
      load_ir(1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      chk("tms5_from_pause_dr", {4'b0, CODE, TEST_LOGIC_RESET}, {4'b0, 2'h2, 1'b1});

      // Code 3 maps to BYPASS
      step(1'b0, 1'b0, 1'b0);
      load_ir(1'b1, 1'b1);
      chk("code3_is_bypass", {5'b0, CODE}, {5'b0, 2'h0});

      // IR scan with a Pause-IR in the middle: bits 1 then 0 -> CODE 1
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("code_after_pause", {5'b0, CODE}, {5'b0, 2'h1});

      // Select-IR with TMS=1 resets CODE on that edge
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("select_ir_to_tlr", {4'b0, CODE, TEST_LOGIC_RESET}, {4'b0, 2'h2, 1'b1});

      // Random walk with occasional asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 249) == 0)
            async_reset("random_reset");
         else
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      @(negedge TCK);
      #3;
      chk("scoreboard_drained", 7'(exp_q.size()), 7'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
